serial_shift_unit: RTL
======================

// Module: serial_shift_unit
// PURPOSE
//  Multi-cycle 32-bit shift unit for the MIPS datapath ALU path (srl/sra/sll, shamt field).
//  It is the right-shifting counterpart of the fixed left-by-2 branch/jump offset scaler:
//  SRL also converts byte addresses to word indices. SLL is kept for completeness.
//  Shifts one bit per clock under a start/busy/done handshake; the control unit stalls on busy.
// PARAMETERS
//  WIDTH   32              data width in bits
//  CNT_W   $clog2(WIDTH)   shift-amount / counter width (5 for WIDTH=32)
// PORTS
//  clk      in   1        single clock, rising edge
//  rst      in   1        asynchronous, active-high reset
//  start    in   1        request; sampled only in IDLE or DONE
//  op       in   2        00=SRL, 01=SRA, 10=SLL, 11=reserved
//  operand  in   WIDTH    value to shift; latched when start is accepted
//  shamt    in   CNT_W    shift amount; latched when start is accepted
//  busy     out  1        high while in SHIFT
//  done     out  1        one-cycle pulse in DONE; result is valid from this cycle
//  result   out  WIDTH    shifted value; held until the next accepted start
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, result=0, count=0, busy=0, done=0.
//  - States: IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE), both decoded from registered state.
//  - Accept: at an edge with start=1 and state in {IDLE,DONE}, latch result<=operand, count<=shamt, op_q<=op.
//    Next state is DONE if shamt==0 (or op==11), otherwise SHIFT.
//  - SHIFT, each edge: result <= step(result, op_q); count <= count-1.
//    If count==1, go to DONE.
//  - Step rules:
//      SRL  {1'b0, r[W-1:1]}
//      SRA  {r[W-1], r[W-1:1]}
//      SLL  {r[W-2:0], 1'b0}
//  - Reserved op 11: no shift; result=operand; done follows the next cycle.
//  - Latency: done is high shamt+1 cycles after the accepting edge. Max 32 cycles (shamt=31).
//  - DONE with no start: go to IDLE next edge; result is held.
//  - DONE with start: accept immediately, back-to-back, with no IDLE bubble.
//  - start while in SHIFT: ignored. No queuing; operand/shamt/op changes have no effect.
//  - Reset mid-SHIFT: aborts; partial result is discarded (result=0). No done pulse is produced.
//  - No wrap-around: count never decrements below 1 in SHIFT; shamt is taken modulo 2^CNT_W by width.
// STRUCTURE
//  - Shared include shift_defs.vh: OP_SRL/OP_SRA/OP_SLL/OP_RSV op encodings; ST_IDLE/ST_SHIFT/ST_DONE state codes.
//  - One sub-module, shift_step_1: combinational single-bit step (in r, op -> out), gate-level like the other
//    datapath shifters. Top-level holds the FSM, counter and result register.
// TESTING
//  1. SRL 0x8000_0000 by 4 -> busy 4 cycles, done on 5th cycle after start; result=0x0800_0000.
//  2. SRA 0x8000_0000 by 4 -> result=0xF800_0000. SRA 0x7FFF_FFF0 by 4 -> result=0x07FF_FFFF.
//  3. SLL 0x0000_0001 by 2 -> result=0x0000_0004 (matches offset scaling).
//     SRL 0x0040_0010 by 2 -> result=0x0010_0004.
//  4. shamt=0 (and op=11), operand 0xDEAD_BEEF -> busy never high; done next cycle; result=0xDEAD_BEEF.
//  5. SRL 0xFFFF_FFFF by 31 -> done 32 cycles after start; result=0x0000_0001.
//     Then start in the DONE cycle -> accepted back-to-back.
//  6. start re-pulsed with new operand during SHIFT -> ignored; first result is unchanged.
//     rst asserted mid-SHIFT -> busy=0, done=0, result=0 immediately, with no done pulse.

Source files
------------

// File: rtl/serial_shift_unit_pkg.sv
// Shared encodings for the serial shift unit: op codes and FSM state codes.
package serial_shift_unit_pkg;

   localparam int SSU_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_SRL = 2'b00,
      OP_SRA = 2'b01,
      OP_SLL = 2'b10,
      OP_RSV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/serial_shift_unit_step.sv
// Combinational single-bit shift step; the reserved op passes the value through.
module shift_step_1
   import serial_shift_unit_pkg::*;
#(
   parameter int WIDTH = SSU_WIDTH
) (
   input  logic [WIDTH-1:0] r,
   input  op_t              op,
   output logic [WIDTH-1:0] out
);

   logic             fill;
   logic [WIDTH-1:0] right;
   logic [WIDTH-1:0] left;
   logic             sel_left;
   logic             sel_hold;

   // Arithmetic right shift replicates the sign bit, logical shifts in zero.
   assign fill     = (op == OP_SRA) & r[WIDTH-1];
   assign right    = {fill, r[WIDTH-1:1]};
   assign left     = {r[WIDTH-2:0], 1'b0};
   assign sel_left = (op == OP_SLL);
   assign sel_hold = (op == OP_RSV);

   assign out = sel_hold ? r : (sel_left ? left : right);

endmodule

// File: rtl/serial_shift_unit.sv
// One-bit-per-clock shifter with start/busy/done handshake; back-to-back starts accepted in DONE.
module serial_shift_unit
   import serial_shift_unit_pkg::*;
#(
   parameter int WIDTH = SSU_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [CNT_W-1:0] shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           state;
   state_t           state_nxt;
   op_t              op_q;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] stepped;
   logic             accept;

   assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

   shift_step_1 #(.WIDTH(WIDTH)) u_step (
      .r   (result),
      .op  (op_q),
      .out (stepped)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start)
               state_nxt = ((shamt == '0) || (op == OP_RSV)) ? ST_DONE : ST_SHIFT;
            else
               state_nxt = ST_IDLE;
         end
         ST_SHIFT: if (count == CNT_W'(1)) state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_SHIFT);
      done = (state == ST_DONE);
   end

   // Result holds after DONE until the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         count  <= '0;
         op_q   <= OP_SRL;
      end else if (accept) begin
         result <= operand;
         count  <= shamt;
         op_q   <= op_t'(op);
      end else if (state == ST_SHIFT) begin
         result <= stepped;
         count  <= count - CNT_W'(1);
      end
   end

endmodule
